cmd_prog_loader: RTL and testbench

- Command-port program loader between the host byte interface (cmd/cmd_valid/address/data_in) and the word-wide instruction/data memory.
- Collects byte writes into full words (big-endian: byte address 4k+0 is the MSB) and commits each word with byte enables.
- Serves byte reads, with forwarding from the assembly buffer, and gates the core with a run signal derived from start_signal.
- Parametrised successor of the fixed 8-bit, 4-byte loader: byte width, address width, bytes per word and memory read latency are all configurable.

---
 rtl/cmd_prog_loader_if.sv | 36 +++
 rtl/cmd_prog_loader.sv | 216 +++++++++++++++++++++
 tb/tb_cmd_prog_loader.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmd_prog_loader_if.sv
// rtl/cmd_prog_loader_if.sv - host command port and word memory port bundle
interface cmd_prog_loader_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int BPW    = 4
);
    localparam int WA_W   = ADDR_W - $clog2(BPW);
    localparam int WORD_W = DATA_W * BPW;

    logic [7:0]        cmd;
    logic              cmd_valid;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              cmd_done;
    logic              cmd_err;
    logic              mem_we;
    logic [BPW-1:0]    mem_be;
    logic [WA_W-1:0]   mem_waddr;
    logic [WORD_W-1:0] mem_wdata;
    logic              mem_re;
    logic [WA_W-1:0]   mem_raddr;
    logic [WORD_W-1:0] mem_rdata;

    modport slave (
        input  cmd, cmd_valid, address, data_in, mem_rdata,
        output data_out, cmd_done, cmd_err,
        output mem_we, mem_be, mem_waddr, mem_wdata, mem_re, mem_raddr
    );

    modport master (
        output cmd, cmd_valid, address, data_in, mem_rdata,
        input  data_out, cmd_done, cmd_err,
        input  mem_we, mem_be, mem_waddr, mem_wdata, mem_re, mem_raddr
    );
endinterface

// File: rtl/cmd_prog_loader.sv
// rtl/cmd_prog_loader.sv - byte command loader into word memory; optional burst writes under CMD_PROG_LOADER_BURST_EN
module cmd_prog_loader #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int BPW    = 4,
    parameter int RD_LAT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    cmd_prog_loader_if.slave   bus,
    input  logic               start_signal,
    output logic               core_run
);
    localparam int LANE_W = $clog2(BPW);
    localparam int WA_W   = ADDR_W - LANE_W;
    localparam int WORD_W = DATA_W * BPW;
    localparam int CNT_W  = $clog2(RD_LAT + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2, FLUSH = 2'd3} state_t;

    // phase inside EXEC: 0 first cycle, 1 load after committing old word, 2 waiting for read data
    typedef struct packed {
        state_t            state;
        logic [1:0]        phase;
        logic [CNT_W-1:0]  wait_cnt;
        logic [7:0]        cmd;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] din;
        logic [WORD_W-1:0] buf_data;
        logic [WA_W-1:0]   buf_word;
        logic [BPW-1:0]    mask;
        logic [DATA_W-1:0] data_q;
        logic              rd_live;
        logic              cmd_done;
        logic              cmd_err;
        logic              mem_we;
        logic [BPW-1:0]    mem_be;
        logic [WA_W-1:0]   mem_waddr;
        logic [WORD_W-1:0] mem_wdata;
        logic              mem_re;
        logic [WA_W-1:0]   mem_raddr;
        logic              start_q;
        logic              start_pend;
        logic              core_run;
`ifdef CMD_PROG_LOADER_BURST_EN
        logic [ADDR_W-1:0] ptr;
`endif
    } regs_t;

    regs_t r, n;

    logic [ADDR_W-1:0] wr_addr;
    logic [WA_W-1:0]   wr_word;
    logic [LANE_W-1:0] wr_sel;
    logic [LANE_W-1:0] rd_sel;
    logic [WORD_W-1:0] ld_data;
    logic [BPW-1:0]    ld_mask;
    logic [DATA_W-1:0] buf_lane;
    logic [DATA_W-1:0] rd_lane;
    logic              is_write;
    logic              is_read;
    logic              rd_hit;
    logic              start_rise;
    logic              start_fall;

`ifdef CMD_PROG_LOADER_BURST_EN
    assign is_write = (r.cmd == 8'd2) || (r.cmd == 8'd3);
    assign wr_addr  = (r.cmd == 8'd3) ? r.ptr : r.addr;
`else
    assign is_write = (r.cmd == 8'd2);
    assign wr_addr  = r.addr;
`endif
    assign is_read    = (r.cmd == 8'd1);
    assign wr_word    = wr_addr[ADDR_W-1:LANE_W];
    // lane 0 sits in the MSBs, so the bit/byte position is the inverted lane index
    assign wr_sel     = ~wr_addr[LANE_W-1:0];
    assign rd_sel     = ~r.addr[LANE_W-1:0];
    assign ld_mask    = r.mask | ({{(BPW-1){1'b0}}, 1'b1} << wr_sel);
    assign buf_lane   = r.buf_data[rd_sel*DATA_W +: DATA_W];
    assign rd_lane    = bus.mem_rdata[rd_sel*DATA_W +: DATA_W];
    assign rd_hit     = r.mask[rd_sel] && (r.addr[ADDR_W-1:LANE_W] == r.buf_word);
    assign start_rise = start_signal && !r.start_q;
    assign start_fall = !start_signal && r.start_q;

    // assembly buffer with the pending byte merged into its lane
    always_comb begin
        ld_data = r.buf_data;
        ld_data[wr_sel*DATA_W +: DATA_W] = r.din;
    end

    // next-state and registered-output logic
    always_comb begin
        n        = r;
        n.mem_we = 1'b0;
        n.mem_re = 1'b0;
        n.start_q = start_signal;
        if (start_rise) n.start_pend = 1'b1;
        if (start_fall) begin
            n.core_run   = 1'b0;
            n.start_pend = 1'b0;
        end
        // memory read data is only guaranteed for one cycle, so capture it
        if (r.rd_live) begin
            n.data_q  = rd_lane;
            n.rd_live = 1'b0;
        end
        unique case (r.state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    n.state   = EXEC;
                    n.phase   = 2'd0;
                    n.cmd     = bus.cmd;
                    n.addr    = bus.address;
                    n.din     = bus.data_in;
                    n.cmd_err = 1'b0;
                end else if (r.start_pend && !start_fall) begin
                    if (r.mask != '0) begin
                        n.state     = FLUSH;
                        n.mem_we    = 1'b1;
                        n.mem_be    = r.mask;
                        n.mem_waddr = r.buf_word;
                        n.mem_wdata = r.buf_data;
                        n.mask      = '0;
                    end else begin
                        n.core_run   = 1'b1;
                        n.start_pend = 1'b0;
                    end
                end
            end
            FLUSH: begin
                n.core_run   = r.start_pend && !start_fall;
                n.start_pend = 1'b0;
                n.state      = IDLE;
            end
            EXEC: begin
                if (r.phase == 2'd2) begin
                    n.wait_cnt = r.wait_cnt - CNT_W'(1);
                    if (r.wait_cnt == CNT_W'(1)) begin
                        n.rd_live  = 1'b1;
                        n.cmd_done = 1'b1;
                        n.state    = DONE;
                    end
                end else if (is_read) begin
                    if (rd_hit) begin
                        n.data_q   = buf_lane;
                        n.cmd_done = 1'b1;
                        n.state    = DONE;
                    end else begin
                        n.mem_re    = 1'b1;
                        n.mem_raddr = r.addr[ADDR_W-1:LANE_W];
                        n.wait_cnt  = CNT_W'(RD_LAT);
                        n.phase     = 2'd2;
                    end
                end else if (is_write) begin
                    if (r.core_run) begin
                        n.cmd_err  = 1'b1;
                        n.cmd_done = 1'b1;
                        n.state    = DONE;
                    end else if ((r.mask != '0) && (wr_word != r.buf_word)) begin
                        n.mem_we    = 1'b1;
                        n.mem_be    = r.mask;
                        n.mem_waddr = r.buf_word;
                        n.mem_wdata = r.buf_data;
                        n.mask      = '0;
                        n.phase     = 2'd1;
                    end else begin
                        n.buf_data = ld_data;
                        n.buf_word = wr_word;
                        n.mask     = ld_mask;
`ifdef CMD_PROG_LOADER_BURST_EN
                        n.ptr      = wr_addr + ADDR_W'(1);
`endif
                        if (&ld_mask) begin
                            n.mem_we    = 1'b1;
                            n.mem_be    = '1;
                            n.mem_waddr = wr_word;
                            n.mem_wdata = ld_data;
                            n.mask      = '0;
                        end
                        n.cmd_done = 1'b1;
                        n.state    = DONE;
                    end
                end else begin
                    n.cmd_err  = 1'b1;
                    n.cmd_done = 1'b1;
                    n.state    = DONE;
                end
            end
            DONE: begin
                if (!bus.cmd_valid) begin
                    n.cmd_done = 1'b0;
                    n.cmd_err  = 1'b0;
                    n.state    = IDLE;
                end
            end
            default: n.state = IDLE;
        endcase
    end

    // state register; reset is active-high on rst_n
    always_ff @(posedge clk) begin
        if (rst_n) r <= '0;
        else       r <= n;
    end

    assign bus.data_out  = r.rd_live ? rd_lane : r.data_q;
    assign bus.cmd_done  = r.cmd_done;
    assign bus.cmd_err   = r.cmd_err;
    assign bus.mem_we    = r.mem_we;
    assign bus.mem_be    = r.mem_be;
    assign bus.mem_waddr = r.mem_waddr;
    assign bus.mem_wdata = r.mem_wdata;
    assign bus.mem_re    = r.mem_re;
    assign bus.mem_raddr = r.mem_raddr;
    assign core_run      = r.core_run;
endmodule

// File: tb/tb_cmd_prog_loader.sv
// tb/tb_cmd_prog_loader.sv - self-checking bench for cmd_prog_loader with a byte-level reference model
module tb_cmd_prog_loader;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;
    localparam int BPW    = 4;
    localparam int RD_LAT = 1;
    localparam int WA_W   = ADDR_W - $clog2(BPW);
    localparam int WORD_W = DATA_W * BPW;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start_signal = 1'b0;
    logic core_run;

    always #5 clk = ~clk;

    cmd_prog_loader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BPW(BPW)) bus ();

    cmd_prog_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BPW(BPW), .RD_LAT(RD_LAT)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .start_signal(start_signal),
        .core_run(core_run)
    );

    // word memory with RD_LAT-stage read pipeline
    logic [WORD_W-1:0] tb_mem  [0:(1<<WA_W)-1];
    logic [WORD_W-1:0] rd_pipe [0:RD_LAT-1];
    always @(posedge clk) begin
        if (bus.mem_we)
            for (int i = 0; i < BPW; i++)
                if (bus.mem_be[i]) tb_mem[bus.mem_waddr][i*DATA_W +: DATA_W] <= bus.mem_wdata[i*DATA_W +: DATA_W];
        if (bus.mem_re) rd_pipe[0] <= tb_mem[bus.mem_raddr];
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bus.mem_rdata = rd_pipe[RD_LAT-1];

    typedef struct packed {
        logic [WA_W-1:0]   waddr;
        logic [BPW-1:0]    be;
        logic [WORD_W-1:0] wdata;
    } wr_t;

    int n_cmp = 0;
    int n_bad = 0;
    int n_we  = 0;
    int n_re  = 0;
    wr_t exp_wq[$];
    wr_t mon_e;
    logic [BPW-1:0]  last_be;
    logic [WA_W-1:0] last_waddr;

    // reference model: committed memory image plus per-byte assembly buffer
    logic [WORD_W-1:0] m_mem [0:(1<<WA_W)-1];
    logic [DATA_W-1:0] m_lane [0:BPW-1];
    bit                m_valid [0:BPW-1];
    int                m_word;
    bit                m_run;
    int                m_ptr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [WORD_W-1:0] be_mask(input logic [BPW-1:0] be);
        logic [WORD_W-1:0] m;
        m = '0;
        for (int i = 0; i < BPW; i++) if (be[i]) m[i*DATA_W +: DATA_W] = '1;
        return m;
    endfunction

    // every write strobe must match the next write the model predicted
    always @(negedge clk) begin
        if (bus.mem_we) begin
            n_we++;
            last_be    = bus.mem_be;
            last_waddr = bus.mem_waddr;
            if (exp_wq.size() == 0) begin
                chk("unexpected_mem_we", 1, 0);
            end else begin
                mon_e = exp_wq.pop_front();
                chk("mem_waddr", bus.mem_waddr, mon_e.waddr);
                chk("mem_be", bus.mem_be, mon_e.be);
                chk("mem_wdata", bus.mem_wdata & be_mask(mon_e.be), mon_e.wdata & be_mask(mon_e.be));
            end
        end
        if (bus.mem_re) n_re++;
        if (bus.mem_we && bus.mem_re) chk("we_re_exclusive", 1, 0);
    end

    function automatic bit m_any();
        bit a;
        a = 0;
        for (int l = 0; l < BPW; l++) a |= m_valid[l];
        return a;
    endfunction

    function automatic bit m_all();
        bit a;
        a = 1;
        for (int l = 0; l < BPW; l++) a &= m_valid[l];
        return a;
    endfunction

    task automatic m_commit();
        wr_t e;
        e = '0;
        for (int l = 0; l < BPW; l++) begin
            if (m_valid[l]) begin
                e.be[BPW-1-l] = 1'b1;
                e.wdata[(BPW-1-l)*DATA_W +: DATA_W] = m_lane[l];
                m_mem[m_word][(BPW-1-l)*DATA_W +: DATA_W] = m_lane[l];
                m_valid[l] = 0;
            end
        end
        e.waddr = m_word[WA_W-1:0];
        exp_wq.push_back(e);
    endtask

    task automatic predict_write(input int addr, input logic [7:0] d, output int lat, output bit err);
        lat = 1;
        err = 0;
        if (m_run) begin
            err = 1;
            return;
        end
        if (m_any() && (addr / BPW) != m_word) begin
            m_commit();
            lat = 2;
        end
        m_word = addr / BPW;
        m_lane[addr % BPW]  = d;
        m_valid[addr % BPW] = 1;
        if (m_all()) m_commit();
    endtask

    task automatic predict_read(input int addr, output logic [7:0] d, output int lat, output int re);
        int l;
        logic [WORD_W-1:0] w;
        l = addr % BPW;
        if (m_valid[l] && m_word == addr / BPW) begin
            d = m_lane[l];
            lat = 1;
            re = 0;
        end else begin
            w = m_mem[addr / BPW];
            d = w[(BPW-1-l)*DATA_W +: DATA_W];
            lat = 1 + RD_LAT;
            re = 1;
        end
    endtask

    task automatic run_cmd(input logic [7:0] c, input int addr, input logic [7:0] d, input int hold, input string tag);
        int lat, ere, re0, k;
        bit err, ok;
        logic [7:0] edata;
        ere = 0;
        edata = '0;
        if (c == 8'd2) begin
            predict_write(addr, d, lat, err);
            if (!err) m_ptr = (addr + 1) % (1 << ADDR_W);
        end
`ifdef CMD_PROG_LOADER_BURST_EN
        else if (c == 8'd3) begin
            predict_write(m_ptr, d, lat, err);
            if (!err) m_ptr = (m_ptr + 1) % (1 << ADDR_W);
        end
`endif
        else if (c == 8'd1) begin
            predict_read(addr, edata, lat, ere);
            err = 0;
        end else begin
            lat = 1;
            err = 1;
        end
        @(negedge clk);
        bus.cmd = c;
        bus.address = addr[ADDR_W-1:0];
        bus.data_in = d;
        bus.cmd_valid = 1'b1;
        re0 = n_re;
        @(posedge clk);
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (!bus.cmd_done && k < 32);
        chk({tag, "_lat"}, k, lat);
        chk({tag, "_err"}, bus.cmd_err, err);
        if (c == 8'd1) chk({tag, "_data"}, bus.data_out, edata);
        if (hold > 0) begin
            ok = 1;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                #1;
                if (!bus.cmd_done) ok = 0;
            end
            chk({tag, "_held"}, ok, 1);
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk({tag, "_mem_re"}, n_re - re0, ere);
        @(posedge clk);
        #1;
        chk({tag, "_release"}, bus.cmd_done, 0);
    endtask

    task automatic start_core(input string tag, output int k);
        if (m_any()) m_commit();
        @(negedge clk);
        start_signal = 1'b1;
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (!core_run && k < 10);
        chk({tag, "_core_run"}, core_run, 1);
        m_run = 1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int k, re0, we0;
        bus.cmd = '0;
        bus.cmd_valid = 1'b0;
        bus.address = '0;
        bus.data_in = '0;
        for (int i = 0; i < (1 << WA_W); i++) m_mem[i] = '0;
        for (int l = 0; l < BPW; l++) m_valid[l] = 0;
        m_word = 0;
        m_run = 0;
        m_ptr = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_cmd_done", bus.cmd_done, 0);
        chk("rst_cmd_err", bus.cmd_err, 0);
        chk("rst_core_run", core_run, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_re", bus.mem_re, 0);
        chk("rst_data_out", bus.data_out, 0);

        // full word assembled from four bytes
        we0 = n_we;
        run_cmd(8'd2, 0, 8'h00, 3, "w0");
        run_cmd(8'd2, 1, 8'h50, 3, "w1");
        run_cmd(8'd2, 2, 8'h01, 3, "w2");
        run_cmd(8'd2, 3, 8'h13, 3, "w3");
        chk("word0_writes", n_we - we0, 1);
        chk("word0_value", tb_mem[0], 32'h00500113);

        // word change commits the partial word first
        run_cmd(8'd2, 7, 8'h93, 0, "w7");
        run_cmd(8'd2, 8, 8'hAA, 0, "w8");
        chk("w8_commit_be", last_be, 4'b0001);
        chk("w8_commit_waddr", last_waddr, 1);
        chk("word1_lsb", tb_mem[1][7:0], 8'h93);

        // forwarding from the buffer, then a memory read
        run_cmd(8'd2, 6, 8'h21, 0, "w6");
        re0 = n_re;
        run_cmd(8'd1, 6, 8'h00, 0, "r6");
        chk("r6_no_mem_re", n_re - re0, 0);
        run_cmd(8'd1, 0, 8'h00, 0, "r0");
        run_cmd(8'd1, 3, 8'h00, 0, "r3");

        // partial word at word 11 flushed by start
        run_cmd(8'd2, 46, 8'h11, 0, "w46");
        run_cmd(8'd2, 47, 8'h22, 0, "w47");
        start_core("start1", k);
        chk("start1_cycles", k, 3);
        chk("flush_be", last_be, 4'b0011);
        chk("flush_waddr", last_waddr, 11);
        we0 = n_we;
        run_cmd(8'd2, 50, 8'h55, 0, "wrun");
        chk("wrun_no_we", n_we - we0, 0);
        run_cmd(8'd1, 47, 8'h00, 0, "rrun");
        @(negedge clk);
        start_signal = 1'b0;
        @(posedge clk);
        #1;
        chk("stop_core_run", core_run, 0);
        m_run = 0;

        // long hold runs the command once
        we0 = n_we;
        run_cmd(8'd2, 20, 8'h5A, 20, "hold");
        chk("hold_no_we", n_we - we0, 0);

        // undefined commands
        run_cmd(8'd0, 4, 8'h00, 0, "nop");
        run_cmd(8'h7F, 4, 8'h00, 0, "undef");
`ifdef CMD_PROG_LOADER_BURST_EN
        run_cmd(8'd2, 15, 8'h99, 0, "w15");
        run_cmd(8'd3, 0, 8'h00, 0, "b0");
        run_cmd(8'd3, 0, 8'h72, 0, "b1");
        run_cmd(8'd3, 0, 8'hC3, 0, "b2");
        run_cmd(8'd3, 0, 8'h13, 0, "b3");
        chk("burst_waddr", last_waddr, 4);
        chk("burst_word", tb_mem[4], 32'h0072C313);
`else
        run_cmd(8'd3, 4, 8'h00, 0, "burst_off");
`endif

        // reset in the middle of a READ while the core runs
        start_core("start2", k);
        @(negedge clk);
        bus.cmd = 8'd1;
        bus.address = 8'h20;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        start_signal = 1'b0;
        bus.cmd_valid = 1'b0;
        re0 = n_re;
        @(posedge clk);
        #1;
        chk("midrst_cmd_done", bus.cmd_done, 0);
        chk("midrst_core_run", core_run, 0);
        @(negedge clk);
        rst_n = 1'b0;
        for (int l = 0; l < BPW; l++) m_valid[l] = 0;
        m_run = 0;
        m_ptr = 0;
        repeat (4) @(posedge clk);
        #1;
        chk("midrst_no_mem_re", n_re - re0, 0);
        run_cmd(8'd1, 1, 8'h00, 0, "post_rst");

        repeat (2) @(posedge clk);
        chk("pending_writes", exp_wq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
